vram_arbiter: RTL and testbench



---
 rtl/vga_pkg.sv | 19 +
 rtl/vram_wr_fifo.sv | 49 ++++
 rtl/vram_arbiter.sv | 143 ++++++++++++++
 tb/tb_vram_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VRAM widths, swap FSM states and the write-request record used by
// the VRAM arbiter and its write FIFO.
package vga_pkg;

    localparam int VRAM_ADDR_W = 15;
    localparam int VRAM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        WAIT_VB
    } swap_state_t;

    typedef struct packed {
        logic [VRAM_ADDR_W-1:0] addr;
        logic [VRAM_DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// Synchronous write-request FIFO; wrap-bit pointers give full/empty, head is
// presented combinationally so the arbiter can issue and pop in one cycle.
module vram_wr_fifo
    import vga_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = wr_req_t,
    localparam int PTR_W = $clog2(DEPTH) + 1
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             push,
    input  T                 push_data,
    input  logic             pop,
    output T                 head,
    output logic             full,
    output logic             empty,
    output logic [PTR_W-1:0] count
);

    localparam int AW = PTR_W - 1;

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    T                 mem [DEPTH];
    logic             do_push, do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge Clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display reads win, buffered writer fills the back
// page, page swap after drain + vblank. Optional stall counter: VRAM_ARB_STATS_EN.
module vram_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W     = VRAM_ADDR_W,
    parameter int DATA_W     = VRAM_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              DispReq,
    input  logic [ADDR_W-1:0] DispAddr,
    output logic [DATA_W-1:0] DispData,
    output logic              DispValid,
    input  logic              WrValid,
    output logic              WrReady,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    input  logic              VBlank,
    input  logic              PageSwapReq,
    output logic              SwapBusy,
    output logic              Page,
    output logic [ADDR_W:0]   RamAddr,
    output logic              RamWe,
    output logic [DATA_W-1:0] RamWData,
    input  logic [DATA_W-1:0] RamRData
`ifdef VRAM_ARB_STATS_EN
    ,
    output logic [15:0]       StallCount
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    req_t             wr_req, head;
    logic             fifo_full, fifo_empty;
    logic             push, pop, full_n;
    logic [PTR_W-1:0] fifo_count, count_n;
    logic [1:0]       disp_vld_pipe;
    swap_state_t      state;

    assign wr_req  = '{addr: WrAddr, data: WrData};
    assign push    = WrValid & WrReady;
    assign pop     = ~DispReq & ~fifo_empty;
    // WrReady is registered, so it is computed from the occupancy after this cycle.
    assign count_n = fifo_count + PTR_W'(push) - PTR_W'(pop);
    assign full_n  = (count_n == PTR_W'(FIFO_DEPTH));

    vram_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (req_t)
    ) u_fifo (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .push      (push),
        .push_data (wr_req),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= IDLE;
            Page     <= 1'b0;
            SwapBusy <= 1'b0;
            WrReady  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (PageSwapReq) begin
                        state    <= DRAIN;
                        SwapBusy <= 1'b1;
                        WrReady  <= 1'b0;
                    end else begin
                        WrReady  <= ~full_n;
                    end
                end
                DRAIN: begin
                    WrReady <= 1'b0;
                    if (fifo_empty && !pop) state <= WAIT_VB;
                end
                WAIT_VB: begin
                    WrReady <= 1'b0;
                    if (VBlank) begin
                        state    <= IDLE;
                        Page     <= ~Page;
                        SwapBusy <= 1'b0;
                        WrReady  <= ~full_n;
                    end
                end
                default: begin
                    state    <= IDLE;
                    SwapBusy <= 1'b0;
                    WrReady  <= 1'b0;
                end
            endcase
        end
    end

    // RAM port: display first, then the FIFO head into the back page; idle holds the address.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            RamAddr       <= '0;
            RamWe         <= 1'b0;
            RamWData      <= '0;
            disp_vld_pipe <= '0;
        end else begin
            disp_vld_pipe <= {disp_vld_pipe[0], DispReq};
            if (DispReq) begin
                RamAddr <= {Page, DispAddr};
                RamWe   <= 1'b0;
            end else if (!fifo_empty) begin
                RamAddr  <= {~Page, head.addr};
                RamWData <= head.data;
                RamWe    <= 1'b1;
            end else begin
                RamWe <= 1'b0;
            end
        end
    end

    assign DispValid = disp_vld_pipe[1];
    assign DispData  = RamRData;

`ifdef VRAM_ARB_STATS_EN
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            StallCount <= '0;
        else if (!fifo_empty && DispReq && StallCount != 16'hFFFF)
            StallCount <= StallCount + 16'd1;
    end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: stimulus queues expected RAM writes and
// display read data, a negedge monitor pops and compares them.
module tb_vram_arbiter;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        DispReq = 1'b0;
    logic [14:0] DispAddr = '0;
    logic [7:0]  DispData;
    logic        DispValid;
    logic        WrValid = 1'b0;
    logic        WrReady;
    logic [14:0] WrAddr = '0;
    logic [7:0]  WrData = '0;
    logic        VBlank = 1'b0;
    logic        PageSwapReq = 1'b0;
    logic        SwapBusy;
    logic        Page;
    logic [15:0] RamAddr;
    logic        RamWe;
    logic [7:0]  RamWData;
    logic [7:0]  RamRData;

    always #5 Clk = ~Clk;

    vram_arbiter dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .DispReq(DispReq), .DispAddr(DispAddr), .DispData(DispData), .DispValid(DispValid),
        .WrValid(WrValid), .WrReady(WrReady), .WrAddr(WrAddr), .WrData(WrData),
        .VBlank(VBlank), .PageSwapReq(PageSwapReq), .SwapBusy(SwapBusy), .Page(Page),
        .RamAddr(RamAddr), .RamWe(RamWe), .RamWData(RamWData), .RamRData(RamRData)
    );

    // RAM model: synchronous read, 1-cycle latency, a few preloaded page-0 words.
    logic [7:0] mem   [0:65535];
    bit         wflag [0:65535];

    function automatic logic [7:0] init_val(input logic [15:0] a);
        case (a)
            16'h0010: return 8'h3C;
            16'h0020: return 8'h5A;
            default:  return 8'h00;
        endcase
    endfunction

    always @(posedge Clk) begin
        if (RamWe) begin
            mem[RamAddr]   <= RamWData;
            wflag[RamAddr] <= 1'b1;
        end
        RamRData <= wflag[RamAddr] ? mem[RamAddr] : init_val(RamAddr);
    end

    int         checks = 0;
    int         failures = 0;
    logic [23:0] exp_wr [$];
    logic [7:0]  exp_rd [$];
    logic [7:0]  rd_exp_val = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (Rst_n) begin
            if (RamWe) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected no write", RamAddr, RamWData);
                end else begin
                    chk("ram_write", {8'h00, RamAddr, RamWData}, {8'h00, exp_wr.pop_front()});
                end
            end
            if (DispValid) begin
                if (exp_rd.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_read: got data %0h expected no DispValid", DispData);
                end else begin
                    chk("disp_data", {24'h0, DispData}, {24'h0, exp_rd.pop_front()});
                end
            end
        end
    end

    task automatic tick();
        if (DispReq) exp_rd.push_back(rd_exp_val);
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic [14:0] a, input logic [7:0] d, input logic pg);
        int n = 0;
        while (!WrReady && n < 50) begin
            tick();
            n++;
        end
        if (!WrReady) begin
            checks++;
            failures++;
            $display("FAIL wr_timeout: got WrReady 0 expected 1 within 50 cycles");
        end
        WrValid = 1'b1;
        WrAddr  = a;
        WrData  = d;
        exp_wr.push_back({pg, a, d});
        tick();
        WrValid = 1'b0;
    endtask

    task automatic read1(input logic [14:0] a, input logic [7:0] expv);
        DispReq    = 1'b1;
        DispAddr   = a;
        rd_exp_val = expv;
        tick();
        DispReq = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_page", Page, 0);
        chk("rst_dispvalid", DispValid, 0);
        chk("rst_ramwe", RamWe, 0);
        chk("rst_ramaddr", RamAddr, 0);
        chk("rst_ramwdata", RamWData, 0);
        chk("rst_wrready", WrReady, 0);
        chk("rst_swapbusy", SwapBusy, 0);
        Rst_n = 1'b1;
        tick();
        chk("wrready_after_reset", WrReady, 1);

        // Three writes with display idle land on back page 1 back-to-back
        wr(15'd5, 8'hAA, 1'b1);
        wr(15'd6, 8'hBB, 1'b1);
        wr(15'd7, 8'hCC, 1'b1);
        chk("t1_we_a", RamWe, 1);
        tick();
        chk("t1_we_b", RamWe, 1);
        tick();
        chk("t1_we_idle", RamWe, 0);
        chk("t1_page", Page, 0);

        // Display held for 10 cycles while the FIFO fills; drain afterwards
        DispAddr   = 15'h20;
        rd_exp_val = 8'h5A;
        DispReq    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i < 4) begin
                chk("t2_wrready_hold", WrReady, 1);
                WrValid = 1'b1;
                WrAddr  = 15'(32'h100 + i);
                WrData  = 8'(32'h10 + i);
                exp_wr.push_back({1'b1, 15'(32'h100 + i), 8'(32'h10 + i)});
            end else begin
                WrValid = 1'b0;
            end
            tick();
            if (i == 3) chk("t2_wrready_full", WrReady, 0);
            chk("t2_no_write_hold", RamWe, 0);
        end
        DispReq = 1'b0;
        WrValid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t2_drain_we", RamWe, 1);
        end
        tick();
        chk("t2_drain_done", RamWe, 0);

        // Single read latency
        DispAddr   = 15'h10;
        rd_exp_val = 8'h3C;
        DispReq    = 1'b1;
        tick();
        DispReq = 1'b0;
        chk("t3_rd_addr", RamAddr, 16'h0010);
        chk("t3_rd_we", RamWe, 0);
        chk("t3_valid_n1", DispValid, 0);
        tick();
        chk("t3_valid_n2", DispValid, 1);
        chk("t3_data_n2", DispData, 8'h3C);
        tick();
        chk("t3_valid_n3", DispValid, 0);

        // Swap with two writes queued behind the display, VBlank low
        DispAddr   = 15'h20;
        rd_exp_val = 8'h5A;
        DispReq    = 1'b1;
        WrValid    = 1'b1;
        WrAddr     = 15'h200;
        WrData     = 8'h11;
        exp_wr.push_back({1'b1, 15'h200, 8'h11});
        tick();
        WrAddr = 15'h201;
        WrData = 8'h22;
        exp_wr.push_back({1'b1, 15'h201, 8'h22});
        tick();
        WrValid     = 1'b0;
        PageSwapReq = 1'b1;
        tick();
        PageSwapReq = 1'b0;
        DispReq     = 1'b0;
        chk("t4_swapbusy", SwapBusy, 1);
        chk("t4_wrready_drain", WrReady, 0);
        repeat (6) tick();
        chk("t4_page_wait", Page, 0);
        chk("t4_busy_wait", SwapBusy, 1);
        chk("t4_wrready_wait", WrReady, 0);
        VBlank = 1'b1;
        tick();
        VBlank = 1'b0;
        chk("t4_page_swapped", Page, 1);
        chk("t4_busy_done", SwapBusy, 0);
        chk("t4_wrready_back", WrReady, 1);

        // Display now sees page 1
        read1(15'd5, 8'hAA);
        read1(15'h10, 8'h00);
        read1(15'h200, 8'h11);
        repeat (3) tick();

        // Second request during WAIT_VB is dropped
        PageSwapReq = 1'b1;
        tick();
        PageSwapReq = 1'b0;
        tick();
        PageSwapReq = 1'b1;
        tick();
        PageSwapReq = 1'b0;
        chk("t5_page_before", Page, 1);
        chk("t5_busy_before", SwapBusy, 1);
        VBlank = 1'b1;
        tick();
        chk("t5_swap_once", Page, 0);
        chk("t5_busy_after", SwapBusy, 0);
        repeat (3) tick();
        chk("t5_no_second_swap", Page, 0);
        chk("t5_no_second_busy", SwapBusy, 0);

        // VBlank already high on entering WAIT_VB; toggle coincides with a read
        PageSwapReq = 1'b1;
        tick();
        PageSwapReq = 1'b0;
        chk("t6_page_drain", Page, 0);
        tick();
        chk("t6_page_waitvb", Page, 0);
        chk("t6_busy_waitvb", SwapBusy, 1);
        DispReq    = 1'b1;
        DispAddr   = 15'h10;
        rd_exp_val = 8'h3C;
        tick();
        chk("t6_page_toggled", Page, 1);
        chk("t6_busy_clear", SwapBusy, 0);
        rd_exp_val = 8'h00;
        tick();
        DispReq = 1'b0;
        VBlank  = 1'b0;
        repeat (3) tick();

        // Reset in DRAIN with a full FIFO
        DispAddr   = 15'h20;
        rd_exp_val = 8'h00;
        DispReq    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            WrValid = 1'b1;
            WrAddr  = 15'(32'h300 + i);
            WrData  = 8'(32'hE0 + i);
            tick();
        end
        WrValid = 1'b0;
        chk("t7_wrready_full", WrReady, 0);
        PageSwapReq = 1'b1;
        tick();
        PageSwapReq = 1'b0;
        chk("t7_busy_drain", SwapBusy, 1);
        #2;
        Rst_n   = 1'b0;
        DispReq = 1'b0;
        #1;
        exp_rd.delete();
        chk("t7_rst_page", Page, 0);
        chk("t7_rst_busy", SwapBusy, 0);
        chk("t7_rst_wrready", WrReady, 0);
        chk("t7_rst_we", RamWe, 0);
        chk("t7_rst_addr", RamAddr, 0);
        chk("t7_rst_wdata", RamWData, 0);
        chk("t7_rst_valid", DispValid, 0);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        repeat (10) tick();
        chk("t7_wrready_release", WrReady, 1);
        read1(15'h10, 8'h3C);
        repeat (3) tick();

        chk("wr_queue_left", exp_wr.size(), 0);
        chk("rd_queue_left", exp_rd.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
